// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Sequencing stage in front of a combinational ripple-carry adder. It accepts
//   an operand set over a valid/ready handshake and drives registered A/B/Cin
//   into the adder. It then holds those inputs for SETTLE_CYCLES cycles so the
//   carry chain can ripple, captures Sum/Cout plus a signed-overflow flag, and
//   presents the result downstream over a second valid/ready handshake.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             upstream operand handshake
//   in_a, in_b, in_cin            operand set
//   add_a, add_b, add_cin         registered adder inputs (change only on accept)
//   add_sum, add_cout             combinational adder return
//   out_valid/out_ready           downstream result handshake
//   out_sum, out_cout, out_ovf    captured result and signed overflow
//   busy                          high while settling or holding a result
module adder_operand_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  localparam logic [7:0] CntInit = 8'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  // A held result may be retired and replaced in the same cycle.
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == StSettle) || (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: ;
      StSettle: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          out_sum_d   = add_sum;
          out_cout_d  = add_cout;
          // Like-signed operands producing an opposite-signed sum.
          out_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != add_a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The adder inputs are only ever loaded here, keeping them stable while settling.
    if (accept) begin
      add_a_d   = in_a;
      add_b_d   = in_b;
      add_cin_d = in_cin;
      cnt_d     = CntInit;
      state_d   = StSettle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer with a behavioural adder attached.
module tb_adder_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  adder_operand_sequencer #(
    .WIDTH        (32),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  // The adder being sequenced.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for a single cycle; returns 1ns after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] s, input logic c,
                            input logic o);
    chk({tag, "_valid"}, {32'd0, out_valid}, 33'd1);
    chk({tag, "_sum"},   {1'b0, out_sum},    {1'b0, s});
    chk({tag, "_cout"},  {32'd0, out_cout},  {32'd0, c});
    chk({tag, "_ovf"},   {32'd0, out_ovf},   {32'd0, o});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_add_a",     {1'b0, add_a},      33'd0);
    chk("rst_busy",      {32'd0, busy},      33'd0);
    chk("rst_in_ready",  {32'd0, in_ready},  33'd1);
    #2 rst_n = 1'b1;
    step();

    // 1: 1 + 1, result appears two edges after accept.
    send(32'h0000_0001, 32'h0000_0001, 1'b0);
    in_a = 32'hDEAD_BEEF;  // must not reach the adder without an accept
    chk("t1_busy",      {32'd0, busy},      33'd1);
    chk("t1_in_ready",  {32'd0, in_ready},  33'd0);
    chk("t1_valid_t1",  {32'd0, out_valid}, 33'd0);
    step();
    chk("t1_valid_t2",  {32'd0, out_valid}, 33'd0);
    chk("t1_add_a_hold", {1'b0, add_a},     33'h0_0000_0001);
    step();
    chk_result("t1", 32'h0000_0002, 1'b0, 1'b0);
    step();
    chk("t1_retired",   {32'd0, out_valid}, 33'd0);
    chk("t1_idle",      {32'd0, busy},      33'd0);

    // 2: carry out, sum wraps to zero.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    step();
    chk_result("t2", 32'h0000_0000, 1'b1, 1'b0);
    step();

    // 3: positive overflow through carry-in.
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    step();
    step();
    chk_result("t3", 32'h8000_0000, 1'b0, 1'b1);
    step();

    // 4: downstream stalls for five cycles.
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk_result("t4_hold", 32'hFFFF_FFFE, 1'b1, 1'b0);
      chk("t4_in_ready", {32'd0, in_ready}, 33'd0);
      chk("t4_add_a",    {1'b0, add_a},     33'h0_FFFF_FFFF);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_retired", {32'd0, out_valid}, 33'd0);
    chk("t4_idle",    {32'd0, busy},      33'd0);
    step();
    chk("t4_single",  {32'd0, out_valid}, 33'd0);

    // 5: back-to-back, second accept on the first retire edge.
    send(32'h1234_5678, 32'h8765_4321, 1'b0);
    step();
    step();
    chk_result("t5a", 32'h9999_9999, 1'b0, 1'b0);
    chk("t5_in_ready_done", {32'd0, in_ready}, 33'd1);
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    chk("t5_retire_valid", {32'd0, out_valid}, 33'd0);
    chk("t5_busy",         {32'd0, busy},      33'd1);
    chk("t5_add_a",        {1'b0, add_a},      33'h0_AAAA_AAAA);
    step();
    chk("t5_valid_mid",    {32'd0, out_valid}, 33'd0);
    step();
    chk_result("t5b", 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    chk("t5_retired",      {32'd0, out_valid}, 33'd0);

    // 6: reset during settle discards the operation.
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    chk("t6_busy_pre", {32'd0, busy}, 33'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {32'd0, out_valid}, 33'd0);
    chk("t6_rst_add_a", {1'b0, add_a},      33'd0);
    chk("t6_rst_busy",  {32'd0, busy},      33'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_result", {32'd0, out_valid}, 33'd0);
    end
    send(32'h0000_0010, 32'h0000_0020, 1'b1);
    step();
    step();
    chk_result("t6_after", 32'h0000_0031, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
